processing_unit_mc: RTL and testbench
=====================================

Name: processing_unit_mc

Overview:
Parametrised, multi-cycle successor of the LC-3 datapath core. It contains a register file, SR1/SR2/DR muxes, a condition-code (NZP) register and an ALU with a start/done handshake. Single-cycle ops (ADD, AND, NOT, PASSA, SHL, SRA) complete in one cycle. MUL is iterative shift-add. The result sits in a holding register that the top module gates onto the bus.

Parameters:
DATA_W, 16, datapath and register width
NUM_REGS, 8, register count (power of 2, >=4)
ADDR_W, $clog2(NUM_REGS), register-address width (derived)
IMM_W, 5, immediate field width, sign-extended to DATA_W

Ports:
i_CLK  in  1  clock
i_RST  in  1  reset
i_LD_REG  in  1  write i_bus into DR at clock edge
i_LD_CC  in  1  update NZP from i_bus at clock edge
i_DR_FIELD  in  ADDR_W  IR destination field
i_SR1_FIELD  in  ADDR_W  IR source-1 field
i_SR2_FIELD  in  ADDR_W  IR source-2 field
i_SR1MUX  in  2  SR1 address select
i_DRMUX  in  2  DR address select
i_IMM_SEL  in  1  SR2 mux: 0=register SR2, 1=SEXT(i_IMM)
i_IMM  in  IMM_W  immediate
i_ALUK  in  3  ALU op
i_START  in  1  start ALU op (one-cycle pulse)
i_bus  in  DATA_W  bus value for register/CC load
o_SR1_Out  out  DATA_W  combinational SR1 read (to address adder)
o_ToBus  out  DATA_W  registered ALU result
o_BUSY  out  1  op in progress
o_DONE  out  1  one-cycle pulse when o_ToBus becomes valid
o_NZP  out  3  condition codes {N,Z,P}

Behaviour:
- Clocking and reset:
  - One clock, i_CLK. Reset is synchronous and active-high on i_RST.
  - At reset: all registers=0, o_ToBus=0, o_BUSY=0, o_DONE=0, o_NZP=3'b010.
  - Reset mid-MUL aborts the op. No o_DONE is issued.
- SR1MUX: 00=i_DR_FIELD, 01=i_SR1_FIELD, 10=NUM_REGS-2 (SP), 11=0.
- DRMUX: 00=i_DR_FIELD, 01=NUM_REGS-2, 10=NUM_REGS-1 (link), 11=0.
- Register file:
  - Asynchronous read on the SR1 and SR2 ports.
  - Synchronous write when i_LD_REG=1.
  - Write and read of the same register in one cycle: the read shows the old value until the edge.
- SR2 operand: register SR2 when i_IMM_SEL=0; otherwise i_IMM sign-extended from bit IMM_W-1.
- ALUK encoding (A=SR1, B=SR2 mux):
  - 000 ADD: A+B mod 2^DATA_W
  - 001 AND
  - 010 NOT A
  - 011 PASSA
  - 100 SHL: A<<B[$clog2(DATA_W)-1:0]
  - 101 SRA: arithmetic right shift, same amount rule as SHL
  - 110 MUL: low DATA_W bits of A*B, unsigned
  - 111: result 0
- FSM states IDLE, MUL_RUN, DONE:
  - IDLE + i_START, single-cycle op: result latched to o_ToBus at that edge, then go to DONE. o_DONE=1 for the next cycle only. Latency 1.
  - IDLE + i_START, MUL: capture A and B at the start edge, clear the accumulator, load counter=DATA_W, go to MUL_RUN.
  - MUL_RUN, each cycle: if B[0] then acc+=A; A<<=1; B>>=1; counter-=1.
  - MUL_RUN when counter reaches 0: acc goes to o_ToBus, go to DONE. Latency DATA_W+1 cycles from i_START to the o_DONE cycle.
  - DONE → IDLE unconditionally.
  - o_BUSY=1 in MUL_RUN and DONE.
- i_START while o_BUSY=1 is ignored (no queueing). i_START during the DONE cycle is also ignored.
- Operands are captured at the start edge. Register writes during MUL_RUN do not affect the product.
- o_ToBus holds its value until the next completion.
- NZP: when i_LD_CC=1, set N=i_bus[DATA_W-1], Z=(i_bus==0), P otherwise. Exactly one bit is set. NZP holds otherwise. NZP is independent of ALU state.
- i_LD_REG and i_LD_CC may both be asserted in the same cycle, and either may be asserted during MUL_RUN. All actions happen independently.

Test Plan:
1. Reset; write R1=0x0005, R2=0x0003 via i_bus/i_LD_REG; start ADD with SR1=R1, SR2=R2 → o_DONE one cycle after start, o_ToBus=0x0008.
2. R1=0x0005, i_IMM=5'b11111, i_IMM_SEL=1, ADD → o_ToBus=0x0004. Then SRA with R1=0x8000 and B=4 → 0xF800.
3. R1=0x0123, R2=0x0045, MUL → o_BUSY for 17 cycles, o_DONE at cycle 17, o_ToBus=0x4E6F. i_START pulsed at cycle 5 is ignored. Writing R1=0 at cycle 3 does not change the result.
4. MUL of 0xFFFF×0xFFFF → o_ToBus=0x0001. Assert i_RST at cycle 8 of the MUL → o_BUSY=0 next cycle, no o_DONE, o_ToBus=0.
5. i_LD_CC with i_bus=0x8000 → NZP=100; 0x0000 → 010; 0x7FFF → 001. DRMUX=10 with i_LD_REG and i_bus=0x3000 → R7=0x3000. SR1MUX=10 reads R6.

Source files
------------

// File: rtl/processing_unit_mc.sv
// Multi-cycle LC-3 style datapath core: register file, SR1/SR2/DR muxes, NZP register, ALU with start/done handshake.
// Single-cycle ops finish 1 cycle after i_START; MUL takes DATA_W+1 cycles; i_START is dropped while o_BUSY.
module processing_unit_mc #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int IMM_W    = 5
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_LD_REG,
    input  logic              i_LD_CC,
    input  logic [ADDR_W-1:0] i_DR_FIELD,
    input  logic [ADDR_W-1:0] i_SR1_FIELD,
    input  logic [ADDR_W-1:0] i_SR2_FIELD,
    input  logic [1:0]        i_SR1MUX,
    input  logic [1:0]        i_DRMUX,
    input  logic              i_IMM_SEL,
    input  logic [IMM_W-1:0]  i_IMM,
    input  logic [2:0]        i_ALUK,
    input  logic              i_START,
    input  logic [DATA_W-1:0] i_bus,
    output logic [DATA_W-1:0] o_SR1_Out,
    output logic [DATA_W-1:0] o_ToBus,
    output logic              o_BUSY,
    output logic              o_DONE,
    output logic [2:0]        o_NZP
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_AND   = 3'b001;
    localparam logic [2:0] ALU_NOT   = 3'b010;
    localparam logic [2:0] ALU_PASSA = 3'b011;
    localparam logic [2:0] ALU_SHL   = 3'b100;
    localparam logic [2:0] ALU_SRA   = 3'b101;
    localparam logic [2:0] ALU_MUL   = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [ADDR_W-1:0] sr1_addr;
    logic [ADDR_W-1:0] dr_addr;
    logic [DATA_W-1:0] sr1_val;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] imm_sext;
    logic [SH_W-1:0]   sh_amt;
    logic [DATA_W-1:0] alu_res;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mula_q, mula_d;
    logic [DATA_W-1:0] mulb_q, mulb_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] acc_step;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tobus_q, tobus_d;
    logic [2:0]        nzp_q;

    always_comb begin
        sr1_addr = '0;
        case (i_SR1MUX)
            2'b00:   sr1_addr = i_DR_FIELD;
            2'b01:   sr1_addr = i_SR1_FIELD;
            2'b10:   sr1_addr = ADDR_W'(NUM_REGS - 2);
            default: sr1_addr = '0;
        endcase
    end

    always_comb begin
        dr_addr = '0;
        case (i_DRMUX)
            2'b00:   dr_addr = i_DR_FIELD;
            2'b01:   dr_addr = ADDR_W'(NUM_REGS - 2);
            2'b10:   dr_addr = ADDR_W'(NUM_REGS - 1);
            default: dr_addr = '0;
        endcase
    end

    // Reads are asynchronous, so a same-cycle write is only visible after the edge.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (i_LD_REG) begin
            regs_q[dr_addr] <= i_bus;
        end
    end

    assign sr1_val  = regs_q[sr1_addr];
    assign imm_sext = {{(DATA_W - IMM_W){i_IMM[IMM_W-1]}}, i_IMM};
    assign opb      = i_IMM_SEL ? imm_sext : regs_q[i_SR2_FIELD];
    assign sh_amt   = opb[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (i_ALUK)
            ALU_ADD:   alu_res = sr1_val + opb;
            ALU_AND:   alu_res = sr1_val & opb;
            ALU_NOT:   alu_res = ~sr1_val;
            ALU_PASSA: alu_res = sr1_val;
            ALU_SHL:   alu_res = sr1_val << sh_amt;
            ALU_SRA:   alu_res = DATA_W'($signed(sr1_val) >>> sh_amt);
            default:   alu_res = '0;
        endcase
    end

    assign acc_step = acc_q + (mulb_q[0] ? mula_q : '0);

    always_comb begin
        state_d = state_q;
        mula_d  = mula_q;
        mulb_d  = mulb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        tobus_d = tobus_q;
        case (state_q)
            S_IDLE: begin
                if (i_START) begin
                    if (i_ALUK == ALU_MUL) begin
                        mula_d  = sr1_val;
                        mulb_d  = opb;
                        acc_d   = '0;
                        cnt_d   = CNT_W'(DATA_W);
                        state_d = S_MUL_RUN;
                    end else begin
                        tobus_d = alu_res;
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL_RUN: begin
                acc_d  = acc_step;
                mula_d = mula_q << 1;
                mulb_d = mulb_q >> 1;
                cnt_d  = cnt_q - CNT_W'(1);
                // Final step: its partial sum goes straight to the output register.
                if (cnt_q == CNT_W'(1)) begin
                    tobus_d = acc_step;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= S_IDLE;
            mula_q  <= '0;
            mulb_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            tobus_q <= '0;
        end else begin
            state_q <= state_d;
            mula_q  <= mula_d;
            mulb_q  <= mulb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tobus_q <= tobus_d;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            nzp_q <= 3'b010;
        end else if (i_LD_CC) begin
            nzp_q <= {i_bus[DATA_W-1], (i_bus == '0), (!i_bus[DATA_W-1] && (i_bus != '0))};
        end
    end

    assign o_SR1_Out = sr1_val;
    assign o_ToBus   = tobus_q;
    assign o_BUSY    = (state_q != S_IDLE);
    assign o_DONE    = (state_q == S_DONE);
    assign o_NZP     = nzp_q;

endmodule

// File: tb/tb_processing_unit_mc.sv
// Bench for processing_unit_mc: vector table, hand-written multi-cycle sequences, randomized ops vs. a reference model.
module tb_processing_unit_mc;

    logic        i_CLK = 1'b0;
    logic        i_RST = 1'b1;
    logic        i_LD_REG = 1'b0;
    logic        i_LD_CC = 1'b0;
    logic [2:0]  i_DR_FIELD = '0;
    logic [2:0]  i_SR1_FIELD = '0;
    logic [2:0]  i_SR2_FIELD = '0;
    logic [1:0]  i_SR1MUX = '0;
    logic [1:0]  i_DRMUX = '0;
    logic        i_IMM_SEL = 1'b0;
    logic [4:0]  i_IMM = '0;
    logic [2:0]  i_ALUK = '0;
    logic        i_START = 1'b0;
    logic [15:0] i_bus = '0;
    logic [15:0] o_SR1_Out;
    logic [15:0] o_ToBus;
    logic        o_BUSY;
    logic        o_DONE;
    logic [2:0]  o_NZP;

    processing_unit_mc dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_LD_REG(i_LD_REG), .i_LD_CC(i_LD_CC),
        .i_DR_FIELD(i_DR_FIELD), .i_SR1_FIELD(i_SR1_FIELD), .i_SR2_FIELD(i_SR2_FIELD),
        .i_SR1MUX(i_SR1MUX), .i_DRMUX(i_DRMUX), .i_IMM_SEL(i_IMM_SEL), .i_IMM(i_IMM),
        .i_ALUK(i_ALUK), .i_START(i_START), .i_bus(i_bus),
        .o_SR1_Out(o_SR1_Out), .o_ToBus(o_ToBus), .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_NZP(o_NZP)
    );

    always #5 i_CLK = ~i_CLK;

    int errors = 0;
    int checks = 0;
    logic [15:0] m_regs [8];
    logic [2:0]  m_nzp;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        isel;
        logic [4:0]  imm;
        logic [2:0]  op;
        logic [15:0] want;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [15:0] sext5(input logic [4:0] v);
        longint s;
        s = v[4] ? longint'(v) - 32 : longint'(v);
        return 16'(s);
    endfunction

    function automatic logic [15:0] model_alu(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        longint la, lb, sa, p, q;
        int amt;
        la  = longint'(a);
        lb  = longint'(b);
        amt = int'(b) % 16;
        p   = longint'(1) << amt;
        sa  = a[15] ? la - 65536 : la;
        case (op)
            3'd0: return 16'((la + lb) % 65536);
            3'd1: return a & b;
            3'd2: return 16'(65535 - la);
            3'd3: return a;
            3'd4: return 16'((la * p) % 65536);
            3'd5: begin
                q = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
                return 16'(q);
            end
            3'd6: return 16'((la * lb) % 65536);
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        longint s;
        s = v[15] ? longint'(v) - 65536 : longint'(v);
        if (s < 0) return 3'b100;
        if (s == 0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    task automatic write_reg(input logic [1:0] drmux, input logic [2:0] field, input logic [15:0] v);
        int dest;
        i_DRMUX = drmux; i_DR_FIELD = field; i_bus = v; i_LD_REG = 1'b1;
        tick();
        i_LD_REG = 1'b0;
        dest = (drmux == 2'd0) ? int'(field) : (drmux == 2'd1) ? 6 : (drmux == 2'd2) ? 7 : 0;
        m_regs[dest] = v;
    endtask

    task automatic load_cc(input logic [15:0] v);
        i_bus = v; i_LD_CC = 1'b1;
        tick();
        i_LD_CC = 1'b0;
        m_nzp = nzp_of(v);
    endtask

    task automatic run_op(input logic [2:0] sr1, input logic [2:0] sr2, input logic isel,
                          input logic [4:0] imm, input logic [2:0] op, input logic [15:0] want,
                          input string nm);
        int lat;
        i_SR1MUX = 2'b01; i_SR1_FIELD = sr1; i_SR2_FIELD = sr2;
        i_IMM_SEL = isel; i_IMM = imm; i_ALUK = op; i_START = 1'b1;
        tick();
        i_START = 1'b0;
        lat = 1;
        while (!o_DONE && lat < 40) begin
            tick();
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), (op == 3'd6) ? 32'd17 : 32'd1);
        chk({nm, "_res"}, 32'(o_ToBus), 32'(want));
        // A start during the DONE cycle must not launch anything.
        i_START = 1'b1; i_ALUK = 3'b111;
        tick();
        i_START = 1'b0;
        chk({nm, "_idle"}, 32'(o_BUSY), 32'd0);
        chk({nm, "_hold"}, 32'(o_ToBus), 32'(want));
    endtask

    initial begin
        int busy_cnt, done_cyc;
        logic done_seen;
        logic [2:0] s1, s2, op;
        logic isel;
        logic [4:0] imm;
        logic [15:0] bval, want;

        vecs[0]  = '{16'h0005, 16'h0003, 1'b0, 5'h00, 3'd0, 16'h0008};
        vecs[1]  = '{16'h0005, 16'h0000, 1'b1, 5'h1F, 3'd0, 16'h0004};
        vecs[2]  = '{16'h8000, 16'h0004, 1'b0, 5'h00, 3'd5, 16'hF800};
        vecs[3]  = '{16'hF0F0, 16'h3C3C, 1'b0, 5'h00, 3'd1, 16'h3030};
        vecs[4]  = '{16'h1234, 16'h0000, 1'b0, 5'h00, 3'd2, 16'hEDCB};
        vecs[5]  = '{16'hBEEF, 16'h1111, 1'b0, 5'h00, 3'd3, 16'hBEEF};
        vecs[6]  = '{16'h0001, 16'h0013, 1'b0, 5'h00, 3'd4, 16'h0008};
        vecs[7]  = '{16'h8001, 16'h0001, 1'b0, 5'h00, 3'd4, 16'h0002};
        vecs[8]  = '{16'h0123, 16'h0045, 1'b0, 5'h00, 3'd6, 16'h4E6F};
        vecs[9]  = '{16'h7777, 16'h1234, 1'b0, 5'h00, 3'd7, 16'h0000};
        vecs[10] = '{16'h4000, 16'h0010, 1'b0, 5'h00, 3'd5, 16'h4000};
        vecs[11] = '{16'hFFFF, 16'h0001, 1'b0, 5'h00, 3'd0, 16'h0000};
        vecs[12] = '{16'h0007, 16'h0000, 1'b1, 5'h10, 3'd6, 16'hFF90};
        vecs[13] = '{16'hFFFF, 16'hFFFF, 1'b0, 5'h00, 3'd6, 16'h0001};

        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_nzp = 3'b010;

        // Reset state
        i_RST = 1'b1;
        tick();
        tick();
        i_RST = 1'b0;
        i_SR1MUX = 2'b01; i_SR1_FIELD = 3'd3;
        #1;
        chk("rst_tobus", 32'(o_ToBus), 32'd0);
        chk("rst_busy", 32'(o_BUSY), 32'd0);
        chk("rst_done", 32'(o_DONE), 32'd0);
        chk("rst_nzp", 32'(o_NZP), 32'(3'b010));
        chk("rst_reg", 32'(o_SR1_Out), 32'd0);

        for (int i = 0; i < 14; i++) begin
            write_reg(2'b00, 3'd1, vecs[i].a);
            write_reg(2'b00, 3'd2, vecs[i].b);
            run_op(3'd1, 3'd2, vecs[i].isel, vecs[i].imm, vecs[i].op, vecs[i].want,
                   $sformatf("vec%0d", i));
        end

        // MUL with operand overwrite at cycle 3 and an ignored start at cycle 5
        write_reg(2'b00, 3'd1, 16'h0123);
        write_reg(2'b00, 3'd2, 16'h0045);
        i_SR1MUX = 2'b01; i_SR1_FIELD = 3'd1; i_SR2_FIELD = 3'd2;
        i_IMM_SEL = 1'b0; i_ALUK = 3'd6; i_START = 1'b1;
        tick();
        i_START = 1'b0;
        busy_cnt = 0; done_cyc = 0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            if (o_BUSY) busy_cnt++;
            if (o_DONE && done_cyc == 0) done_cyc = cyc;
            i_DRMUX = 2'b00; i_DR_FIELD = 3'd1; i_bus = 16'h0000;
            i_LD_REG = (cyc == 3);
            i_START = (cyc == 5);
            tick();
        end
        i_LD_REG = 1'b0; i_START = 1'b0;
        m_regs[1] = 16'h0000;
        chk("mul_busy_cycles", 32'(busy_cnt), 32'd17);
        chk("mul_done_cycle", 32'(done_cyc), 32'd17);
        chk("mul_result", 32'(o_ToBus), 32'h4E6F);
        chk("mul_r1_written", 32'(o_SR1_Out), 32'd0);
        chk("mul_idle_after", 32'(o_BUSY), 32'd0);

        // Reset at cycle 8 of a MUL
        write_reg(2'b00, 3'd1, 16'hFFFF);
        write_reg(2'b00, 3'd2, 16'hFFFF);
        run_op(3'd1, 3'd2, 1'b0, 5'h00, 3'd6, 16'h0001, "mulff");
        i_ALUK = 3'd6; i_START = 1'b1;
        tick();
        i_START = 1'b0;
        for (int cyc = 1; cyc < 8; cyc++) tick();
        i_RST = 1'b1;
        tick();
        i_RST = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_nzp = 3'b010;
        chk("abort_busy", 32'(o_BUSY), 32'd0);
        chk("abort_done", 32'(o_DONE), 32'd0);
        chk("abort_tobus", 32'(o_ToBus), 32'd0);
        chk("abort_reg", 32'(o_SR1_Out), 32'd0);
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (o_DONE) done_seen = 1'b1;
            tick();
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);

        // Condition codes and address muxes
        load_cc(16'h8000);
        chk("nzp_neg", 32'(o_NZP), 32'(m_nzp));
        load_cc(16'h0000);
        chk("nzp_zero", 32'(o_NZP), 32'(m_nzp));
        load_cc(16'h7FFF);
        chk("nzp_pos", 32'(o_NZP), 32'(3'b001));
        i_DRMUX = 2'b10; i_bus = 16'h3000; i_LD_REG = 1'b1; i_LD_CC = 1'b1;
        tick();
        i_LD_REG = 1'b0; i_LD_CC = 1'b0;
        m_regs[7] = 16'h3000;
        chk("nzp_with_reg", 32'(o_NZP), 32'(3'b001));
        i_SR1MUX = 2'b01; i_SR1_FIELD = 3'd7;
        #1;
        chk("drmux_link", 32'(o_SR1_Out), 32'h3000);
        write_reg(2'b01, 3'd0, 16'h6666);
        i_SR1MUX = 2'b10;
        #1;
        chk("sr1mux_sp", 32'(o_SR1_Out), 32'h6666);
        i_SR1MUX = 2'b00; i_DR_FIELD = 3'd7;
        #1;
        chk("sr1mux_dr", 32'(o_SR1_Out), 32'h3000);
        write_reg(2'b11, 3'd5, 16'h0BAD);
        i_SR1MUX = 2'b11;
        #1;
        chk("mux_r0", 32'(o_SR1_Out), 32'h0BAD);
        i_SR1MUX = 2'b01; i_SR1_FIELD = 3'd3;
        i_DRMUX = 2'b00; i_DR_FIELD = 3'd3; i_bus = 16'hAAAA; i_LD_REG = 1'b1;
        #1;
        chk("rd_before_wr", 32'(o_SR1_Out), 32'(m_regs[3]));
        tick();
        i_LD_REG = 1'b0;
        m_regs[3] = 16'hAAAA;
        chk("rd_after_wr", 32'(o_SR1_Out), 32'hAAAA);

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            write_reg(2'b00, 3'($urandom_range(0, 7)), 16'($urandom));
            write_reg(2'b00, 3'($urandom_range(0, 7)), 16'($urandom));
            load_cc(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
            chk($sformatf("rnd%0d_nzp", n), 32'(o_NZP), 32'(m_nzp));
            s1 = 3'($urandom_range(0, 7));
            s2 = 3'($urandom_range(0, 7));
            op = 3'($urandom_range(0, 7));
            isel = 1'($urandom_range(0, 1));
            imm = 5'($urandom);
            bval = isel ? sext5(imm) : m_regs[s2];
            want = model_alu(m_regs[s1], bval, op);
            i_SR1MUX = 2'b01; i_SR1_FIELD = s1;
            #1;
            chk($sformatf("rnd%0d_sr1", n), 32'(o_SR1_Out), 32'(m_regs[s1]));
            run_op(s1, s2, isel, imm, op, want, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
